// File: rtl/bf16_cast_pkg.sv
// Shared types and constants for the BF16 <-> INT16 cast scheduler.
// The opcode constants follow fpnew_pkg::operation_e so the cast datapath can be driven directly.
package bf16_cast_pkg;

   typedef enum logic {
      CAST_F2I = 1'b0,
      CAST_I2F = 1'b1
   } cast_op_e;

   localparam int BF16_W   = 16;
   localparam int INT_W    = 16;
   localparam int STATUS_W = 5;

   // fpnew operation_e encodings for F2I and I2F
   localparam logic [3:0] FPNEW_OP_F2I = 4'd11;
   localparam logic [3:0] FPNEW_OP_I2F = 4'd12;

   function automatic logic [3:0] cast_op_to_fpnew(input cast_op_e op);
      return (op == CAST_I2F) ? FPNEW_OP_I2F : FPNEW_OP_F2I;
   endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin pick: the first eligible index at or after the pointer wins.
// Purely combinational. It can be reused by other shared-FP schedulers.
module rr_arbiter_onehot #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   logic [NUM_REQ-1:0] upper_mask;
   logic [NUM_REQ-1:0] upper_elig;
   logic [NUM_REQ-1:0] search;

   always_comb begin
      upper_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         upper_mask[i] = (IDX_W'(i) >= pointer);
      end
      upper_elig = eligible & upper_mask;
      // wrap to the bottom only when nothing at or above the pointer is eligible
      search     = (|upper_elig) ? upper_elig : eligible;
   end

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (search[i]) begin
            grant     = '0;
            grant[i]  = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
      grant_any = |search;
   end

endmodule

// File: rtl/bf16_cast_sched.sv
// Round-robin scheduler sharing one fixed-latency BF16 cast unit between NUM_REQ requesters.
// Define BF16_CAST_SCHED_PERF_EN to add per-requester saturating grant/stall counters.
module bf16_cast_sched
   import bf16_cast_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int UNIT_LAT = 2,
   parameter int TAG_W    = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [BF16_W*NUM_REQ-1:0]    req_data,
   input  logic [NUM_REQ-1:0]           req_op,
   output logic [NUM_REQ-1:0]           rsp_valid,
   input  logic [NUM_REQ-1:0]           rsp_ready,
   output logic [BF16_W*NUM_REQ-1:0]    rsp_data,
   output logic [STATUS_W*NUM_REQ-1:0]  rsp_status,
   output logic                         unit_in_valid,
   output logic [BF16_W-1:0]            unit_in_data,
   output logic                         unit_in_op,
   input  logic [BF16_W-1:0]            unit_out_data,
   input  logic [STATUS_W-1:0]          unit_out_status
`ifdef BF16_CAST_SCHED_PERF_EN
   ,
   output logic [32*NUM_REQ-1:0]        perf_grant_cnt,
   output logic [32*NUM_REQ-1:0]        perf_stall_cnt
`endif
);

   logic [NUM_REQ-1:0]          busy_q;
   logic [TAG_W-1:0]            ptr_q;
   logic [NUM_REQ-1:0]          eligible;
   logic [NUM_REQ-1:0]          grant_raw;
   logic [NUM_REQ-1:0]          grant;
   logic [TAG_W-1:0]            grant_idx;
   logic                        grant_any_raw;
   logic                        grant_any;
   cast_op_e                    issue_op;

   logic [UNIT_LAT-1:0]         sr_valid_q;
   logic [TAG_W-1:0]            sr_tag_q [UNIT_LAT];
   logic                        exit_valid;
   logic [TAG_W-1:0]            exit_tag;

   logic [NUM_REQ-1:0]          rsp_valid_q;
   logic [BF16_W*NUM_REQ-1:0]   rsp_data_q;
   logic [STATUS_W*NUM_REQ-1:0] rsp_status_q;
   logic [NUM_REQ-1:0]          rsp_hs;
   logic [NUM_REQ-1:0]          capture;

   assign eligible = req_valid & ~busy_q;

   rr_arbiter_onehot #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (TAG_W)
   ) u_arb (
      .eligible  (eligible),
      .pointer   (ptr_q),
      .grant     (grant_raw),
      .grant_idx (grant_idx),
      .grant_any (grant_any_raw)
   );

   // no handshake may complete while reset is asserted
   assign grant     = grant_raw & {NUM_REQ{~rst}};
   assign grant_any = grant_any_raw & ~rst;

   assign req_ready     = grant;
   assign issue_op      = grant_any ? cast_op_e'(req_op[grant_idx]) : CAST_F2I;
   assign unit_in_valid = grant_any;
   assign unit_in_data  = grant_any ? req_data[grant_idx*BF16_W +: BF16_W] : '0;
   assign unit_in_op    = issue_op;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (grant_any) begin
         ptr_q <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_valid_q <= '0;
         for (int s = 0; s < UNIT_LAT; s++) begin
            sr_tag_q[s] <= '0;
         end
      end else begin
         sr_valid_q[0] <= grant_any;
         sr_tag_q[0]   <= grant_idx;
         for (int s = 1; s < UNIT_LAT; s++) begin
            sr_valid_q[s] <= sr_valid_q[s-1];
            sr_tag_q[s]   <= sr_tag_q[s-1];
         end
      end
   end

   assign exit_valid = sr_valid_q[UNIT_LAT-1];
   assign exit_tag   = sr_tag_q[UNIT_LAT-1];

   always_comb begin
      rsp_hs  = '0;
      capture = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_hs[i]  = rsp_valid_q[i] & rsp_ready[i];
         capture[i] = exit_valid & (exit_tag == TAG_W'(i));
      end
   end

   // busy spans issue through response handshake, so a full slot never sees a second return
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
               busy_q[i] <= 1'b1;
            end else if (rsp_hs[i]) begin
               busy_q[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (capture[i]) begin
               rsp_valid_q[i]                         <= 1'b1;
               rsp_data_q[i*BF16_W +: BF16_W]         <= unit_out_data;
               rsp_status_q[i*STATUS_W +: STATUS_W]   <= unit_out_status;
            end else if (rsp_hs[i]) begin
               rsp_valid_q[i] <= 1'b0;
            end
         end
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_status = rsp_status_q;

`ifdef BF16_CAST_SCHED_PERF_EN
   logic [31:0] grant_cnt_q [NUM_REQ];
   logic [31:0] stall_cnt_q [NUM_REQ];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_q[i] <= '0;
            stall_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && (grant_cnt_q[i] != '1)) begin
               grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
            end
            if (req_valid[i] && !grant[i] && (stall_cnt_q[i] != '1)) begin
               stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
      assign perf_grant_cnt[32*g +: 32] = grant_cnt_q[g];
      assign perf_stall_cnt[32*g +: 32] = stall_cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_bf16_cast_sched.sv
// Directed self-checking bench for bf16_cast_sched with a behavioural 2-cycle cast unit.
module tb_bf16_cast_sched;

   localparam int N   = 4;
   localparam int LAT = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [16*N-1:0] req_data;
   logic [N-1:0]    req_op;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [16*N-1:0] rsp_data;
   logic [5*N-1:0]  rsp_status;
   logic            unit_in_valid;
   logic [15:0]     unit_in_data;
   logic            unit_in_op;
   logic [15:0]     unit_out_data;
   logic [4:0]      unit_out_status;
`ifdef BF16_CAST_SCHED_PERF_EN
   logic [32*N-1:0] perf_grant_cnt;
   logic [32*N-1:0] perf_stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bf16_cast_sched #(.NUM_REQ(N), .UNIT_LAT(LAT)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_data        (req_data),
      .req_op          (req_op),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .rsp_status      (rsp_status),
      .unit_in_valid   (unit_in_valid),
      .unit_in_data    (unit_in_data),
      .unit_in_op      (unit_in_op),
      .unit_out_data   (unit_out_data),
      .unit_out_status (unit_out_status)
`ifdef BF16_CAST_SCHED_PERF_EN
      ,
      .perf_grant_cnt  (perf_grant_cnt),
      .perf_stall_cnt  (perf_stall_cnt)
`endif
   );

   // cast unit stand-in: known vectors give the real fpnew answer, anything else a tagged pattern
   function automatic logic [20:0] unit_fn(input logic op, input logic [15:0] d);
      case ({op, d})
         {1'b0, 16'h4060}: return {5'b00001, 16'h0004};
         {1'b0, 16'h4020}: return {5'b00001, 16'h0002};
         {1'b1, 16'h0005}: return {5'b00000, 16'h40A0};
         {1'b0, 16'hBF80}: return {5'b00000, 16'hFFFF};
         default:          return {op, 4'b0000, d ^ 16'hA5A5};
      endcase
   endfunction

   logic [LAT-1:0] pv = '0;
   logic [15:0]    pd [LAT];
   logic           po [LAT];

   always @(posedge clk) begin
      pv[0] <= unit_in_valid;
      pd[0] <= unit_in_data;
      po[0] <= unit_in_op;
      for (int s = 1; s < LAT; s++) begin
         pv[s] <= pv[s-1];
         pd[s] <= pd[s-1];
         po[s] <= po[s-1];
      end
   end

   always_comb begin
      if (pv[LAT-1]) {unit_out_status, unit_out_data} = unit_fn(po[LAT-1], pd[LAT-1]);
      else           {unit_out_status, unit_out_data} = {5'h1F, 16'hDEAD};
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   // a full slot must never be granted again
   always begin
      @(negedge clk);
      #3;
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            assert (!(rsp_valid[i] && req_ready[i])) else begin
               errors++;
               $error("FAIL slot_full_grant: requester %0d observed ready=1 expected 0", i);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_routes(input string tag);
      for (int k = 0; k < N; k++) begin
         if (rsp_valid[k]) begin
            chk(tag, 64'({rsp_status[k*5 +: 5], rsp_data[k*16 +: 16]}),
                64'(unit_fn(req_op[k], req_data[k*16 +: 16])));
         end
      end
   endtask

   task automatic single(input int i, input logic op, input logic [15:0] d,
                         input logic [15:0] ed, input logic [4:0] es, input string tag);
      int lat;
      cyc();
      req_valid[i] = 1'b1;
      req_data[i*16 +: 16] = d;
      req_op[i] = op;
      #1;
      chk({tag, "_ready"}, 64'(req_ready), 64'(1) << i);
      chk({tag, "_unit_in"}, 64'({unit_in_valid, unit_in_op, unit_in_data}), 64'({1'b1, op, d}));
      cyc();
      req_valid[i] = 1'b0;
      lat = 1;
      while (!rsp_valid[i] && lat < 10) begin
         cyc();
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(3));
      chk({tag, "_data"}, 64'(rsp_data[i*16 +: 16]), 64'(ed));
      chk({tag, "_status"}, 64'(rsp_status[i*5 +: 5]), 64'(es));
      cyc();
      chk({tag, "_released"}, 64'(rsp_valid[i]), 64'(0));
   endtask

   initial begin
      int n0, n1, lat;
      logic [20:0] exp_r;

      rst       = 1'b1;
      req_valid = 4'hF;
      req_data  = 64'h1111_2222_3333_4444;
      req_op    = 4'b0101;
      rsp_ready = 4'hF;
      cyc();
      cyc();
      #1;
      chk("reset_req_ready", 64'(req_ready), 64'(0));
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_rsp_data", rsp_data, 64'(0));
      chk("reset_rsp_status", 64'(rsp_status), 64'(0));
      chk("reset_unit_in", 64'({unit_in_valid, unit_in_op, unit_in_data}), 64'(0));
      req_valid = '0;
      cyc();
      rst = 1'b0;

      // single ops: F2I with rounding, I2F, negative F2I
      single(0, 1'b0, 16'h4060, 16'h0004, 5'b00001, "f2i_3p5");
      single(0, 1'b0, 16'h4020, 16'h0002, 5'b00001, "f2i_2p5_rne");
      single(1, 1'b1, 16'h0005, 16'h40A0, 5'b00000, "i2f_5");
      single(2, 1'b0, 16'hBF80, 16'hFFFF, 5'b00000, "f2i_neg1");

      // contention: pointer sits at 3 after the last grant to requester 2
      cyc();
      for (int k = 0; k < N; k++) begin
         req_data[k*16 +: 16] = 16'h1000 + 16'(k);
         req_op[k] = (k % 2 == 1);
      end
      req_valid = 4'hF;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) cyc();
         #1;
         chk("rr_grant", 64'(req_ready), 64'(1) << ((3 + c) % 4));
         check_routes("rr_route");
      end
      cyc();
      req_valid = '0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check_routes("rr_drain_route");
         cyc();
      end

      // backpressure on requester 0 while requester 1 keeps flowing
      rsp_ready = 4'b1110;
      req_data[15:0] = 16'h4060;
      req_op[0] = 1'b0;
      req_data[31:16] = 16'h1234;
      req_op[1] = 1'b1;
      req_valid = 4'b0011;
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) cyc();
         #1;
         if (req_ready[0]) n0++;
         if (req_ready[1]) n1++;
      end
      chk("bp_grants_req0", 64'(n0), 64'(1));
      chk("bp_grants_req1", 64'(n1), 64'(3));
      cyc();
      req_valid = 4'b0001;
      repeat (4) cyc();
      #1;
      chk("bp_slot_full", 64'(rsp_valid), 64'(4'b0001));
      chk("bp_slot_data", 64'({rsp_status[4:0], rsp_data[15:0]}), 64'({5'b00001, 16'h0004}));
      chk("bp_blocked", 64'(req_ready), 64'(0));
      cyc();
      rsp_ready = 4'hF;
      #1;
      chk("bp_release_cycle_ready", 64'(req_ready), 64'(0));
      cyc();
      #1;
      chk("bp_regrant", 64'(req_ready), 64'(4'b0001));
      cyc();
      req_valid = '0;
      repeat (5) cyc();

      // reset while two ops are in flight; pointer would otherwise favour requester 3
      req_data[63:48] = 16'h4060;
      req_op[3] = 1'b0;
      req_valid = 4'b1000;
      #1;
      chk("rst_issue_req3", 64'(req_ready), 64'(4'b1000));
      cyc();
      req_data[47:32] = 16'h4020;
      req_op[2] = 1'b0;
      req_valid = 4'b0100;
      #1;
      chk("rst_issue_req2", 64'(req_ready), 64'(4'b0100));
      cyc();
      rst = 1'b1;
      req_valid = 4'b1010;
      #1;
      chk("rst_ready_gated", 64'(req_ready), 64'(0));
      cyc();
      rst = 1'b0;
      req_valid = '0;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk("rst_no_rsp", 64'(rsp_valid), 64'(0));
         cyc();
      end
      req_valid = 4'b1010;
      #1;
      chk("rst_ptr_lowest", 64'(req_ready), 64'(4'b0010));
      exp_r = unit_fn(req_op[1], req_data[31:16]);
      cyc();
      req_valid = '0;
      lat = 1;
      while (!rsp_valid[1] && lat < 10) begin
         cyc();
         lat++;
      end
      chk("rst_post_latency", 64'(lat), 64'(3));
      chk("rst_post_result", 64'({rsp_status[9:5], rsp_data[31:16]}), 64'(exp_r));
      repeat (3) cyc();

`ifdef BF16_CAST_SCHED_PERF_EN
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk("perf_clear", 64'(perf_grant_cnt[63:32]), 64'(0));
      cyc();
      rsp_ready = 4'b1101;
      req_valid = 4'b0010;
      #1;
      chk("perf_grant_req1", 64'(req_ready), 64'(4'b0010));
      repeat (6) cyc();
      chk("perf_grant_cnt1", 64'(perf_grant_cnt[63:32]), 64'(1));
      chk("perf_stall_cnt1", 64'(perf_stall_cnt[63:32]), 64'(5));
      chk("perf_stall_cnt0", 64'(perf_stall_cnt[31:0]), 64'(0));
      req_valid = '0;
      rsp_ready = 4'hF;
      repeat (3) cyc();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
